// File: rtl/i2c_reg_slave.sv
// Clock-synchronous I2C slave giving byte-wide write/read access to an external register bank.
// SCL/SDA are oversampled, glitch-filtered and decoded into bit, START and STOP events.
module i2c_reg_slave #(
  parameter logic [6:0]  I2C_ADDR = 7'h47,
  parameter int unsigned NUM_REGS = 11,
  parameter int unsigned REG_AW   = 4,
  parameter bit          AUTO_INC = 1'b1,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAAck,
    StReg,
    StRAck,
    StWData,
    StDAck,
    StRData,
    StMAck
  } state_e;

  function automatic logic majority(input logic [FILT_LEN-1:0] w);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < FILT_LEN; i++) begin
      ones += {31'b0, w[i]};
    end
    return (ones > (FILT_LEN / 2));
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_win_q, sda_win_q;
  logic                scl_f_q, sda_f_q;
  logic                scl_maj, sda_maj;
  logic                scl_rise, scl_fall, sda_rise, sda_fall;
  logic                start_ev, stop_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_win_q  <= '1;
      sda_win_q  <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_win_q  <= (scl_win_q << 1) | FILT_LEN'(scl_sync_q[1]);
      sda_win_q  <= (sda_win_q << 1) | FILT_LEN'(sda_sync_q[1]);
      scl_f_q    <= scl_maj;
      sda_f_q    <= sda_maj;
    end
  end

  assign scl_maj  = majority(scl_win_q);
  assign sda_maj  = majority(sda_win_q);
  assign scl_rise = scl_maj & ~scl_f_q;
  assign scl_fall = ~scl_maj & scl_f_q;
  assign sda_rise = sda_maj & ~sda_f_q;
  assign sda_fall = ~sda_maj & sda_f_q;
  assign start_ev = sda_fall & scl_f_q;
  assign stop_ev  = sda_rise & scl_f_q;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_load_q, rd_load_d;

  logic [7:0]        byte_in;
  logic              rx_state, rx_done, idx_ok;
  logic [REG_AW-1:0] ptr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      rd_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_pend_q <= wr_pend_d;
      rd_load_q <= rd_load_d;
    end
  end

  // The byte as it stands once the bit sampled on this SCL rise is included.
  assign byte_in  = {shift_q[6:0], sda_f_q};
  assign rx_state = (state_q == StAddr) || (state_q == StReg) || (state_q == StWData);
  assign rx_done  = rx_state && scl_rise && (cnt_q == 3'd7);
  assign idx_ok   = (32'(byte_in) < NUM_REGS);
  assign ptr_inc  = (ptr_q == REG_AW'(NUM_REGS - 1)) ? '0 : ptr_q + REG_AW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_pend_d = 1'b0;
    rd_load_d = 1'b0;

    // rd_addr follows ptr_q, so read data is captured one cycle after the pointer moves.
    if (rd_load_q) shift_d = rd_data;
    if (wr_en && AUTO_INC) ptr_d = ptr_inc;

    if (stop_ev) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_ev) begin
      state_d = StAddr;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d = byte_in;
        cnt_d   = cnt_q + 3'd1;
      end
      if (rx_state && scl_fall) oe_d = 1'b0;

      case (state_q)
        StIdle: begin
        end
        StAddr: begin
          if (rx_done) begin
            if (byte_in[7:1] == I2C_ADDR) begin
              state_d = StAAck;
              busy_d  = 1'b1;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        StAAck: begin
          if (scl_fall) oe_d = 1'b1;
          if (scl_rise) begin
            cnt_d = 3'd0;
            if (shift_q[0]) begin
              state_d   = StRData;
              rd_load_d = 1'b1;
            end else begin
              state_d = StReg;
            end
          end
        end
        StReg: begin
          if (rx_done) begin
            if (idx_ok) begin
              ptr_d   = byte_in[REG_AW-1:0];
              state_d = StRAck;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        StRAck, StDAck: begin
          if (scl_fall) oe_d = 1'b1;
          if (scl_rise) begin
            state_d = StWData;
            cnt_d   = 3'd0;
          end
        end
        StWData: begin
          if (rx_done) begin
            data_d    = byte_in;
            wr_pend_d = 1'b1;
            state_d   = StDAck;
          end
        end
        StRData: begin
          if (scl_fall) begin
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b1};
          end
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = StMAck;
          end
        end
        StMAck: begin
          if (scl_fall) oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda_f_q) begin
              if (AUTO_INC) ptr_d = ptr_inc;
              rd_load_d = 1'b1;
              cnt_d     = 3'd0;
              state_d   = StRData;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // A bus condition landing on the strobe cycle aborts the byte.
  assign wr_en   = wr_pend_q & ~start_ev & ~stop_ev;
  assign wr_addr = ptr_q;
  assign wr_data = data_q;
  assign rd_addr = ptr_q;
  assign sda_oe  = oe_q;
  assign busy    = busy_q;

endmodule
